// File: rtl/tx_sr_pkg.sv
// Shared transmit/receive shift-register constants.
// The state type is kept here so both directions agree on word ordering and encoding.
package tx_sr_pkg;

   localparam int BYTES_PER_WORD  = 4;
   localparam int BYTES_PER_BLOCK = 16;
   localparam int WORD_W          = 8 * BYTES_PER_WORD;
   localparam int BLOCK_W         = 8 * BYTES_PER_BLOCK;
   localparam int NUM_WORDS       = BYTES_PER_BLOCK / BYTES_PER_WORD;
   localparam int CNT_W           = $clog2(NUM_WORDS + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

endpackage

// File: rtl/flexbyte_pts_sr.sv
// Parallel-to-serial byte shift register.
// It emits the most significant output word first and fills the vacated bits with zeros.
module flexbyte_pts_sr #(
   parameter int NUM_BYTES_IN  = 16,
   parameter int NUM_BYTES_OUT = 4
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         clear,
   input  logic                         load_enable,
   input  logic                         shift_enable,
   input  logic [8*NUM_BYTES_IN-1:0]    parallel_in,
   output logic [8*NUM_BYTES_OUT-1:0]   serial_out
);

   localparam int IN_W  = 8 * NUM_BYTES_IN;
   localparam int OUT_W = 8 * NUM_BYTES_OUT;

   logic [IN_W-1:0] sr_r;

   // Shift register: clear beats load, and load beats shift, so a reload on the last word wins
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_r <= '0;
      end else if (clear) begin
         sr_r <= '0;
      end else if (load_enable) begin
         sr_r <= parallel_in;
      end else if (shift_enable) begin
         sr_r <= {sr_r[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
      end else begin
         sr_r <= sr_r;
      end
   end

   assign serial_out = sr_r[IN_W-1 -: OUT_W];

endmodule

// File: rtl/tx_sr.sv
// Transmit shift register: it accepts one 128-bit block and sends it as 32-bit words, most significant word first.
// Both sides use valid/ready handshakes, and a new block can load during the last-word handshake.
module tx_sr
   import tx_sr_pkg::*;
#(
   parameter int NUM_BYTES_OUT = tx_sr_pkg::BYTES_PER_WORD,
   parameter int NUM_BYTES_IN  = tx_sr_pkg::BYTES_PER_BLOCK
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [8*NUM_BYTES_IN-1:0]   data_in,
   input  logic                        load_en,
   output logic                        load_ready,
   input  logic                        clear,
   output logic [8*NUM_BYTES_OUT-1:0]  data_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        tx_done
);

   localparam int NW = NUM_BYTES_IN / NUM_BYTES_OUT;
   localparam int CW = $clog2(NW + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(NW);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   tx_state_t        state_r;
   tx_state_t        state_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_nxt_s;
   logic             out_valid_r;
   logic             out_valid_nxt_s;
   logic             tx_done_r;
   logic             tx_done_nxt_s;
   logic             load_ready_s;
   logic             load_hs_s;
   logic             shift_hs_s;
   logic             last_hs_s;

   assign shift_hs_s = (state_r == SEND) && out_ready && !clear;
   assign last_hs_s  = shift_hs_s && (cnt_r == CNT_ONE);

   // State, counter and registered status outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         out_valid_r <= 1'b0;
         tx_done_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         tx_done_r   <= tx_done_nxt_s;
      end
   end

   // Next state and counter
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (clear) begin
         state_nxt_s = IDLE;
         cnt_nxt_s   = CNT_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (load_hs_s) begin
                  state_nxt_s = SEND;
                  cnt_nxt_s   = CNT_FULL;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            SEND: begin
               if (load_hs_s) begin
                  state_nxt_s = SEND;
                  cnt_nxt_s   = CNT_FULL;
               end else if (last_hs_s) begin
                  state_nxt_s = IDLE;
                  cnt_nxt_s   = CNT_ZERO;
               end else if (shift_hs_s) begin
                  cnt_nxt_s   = cnt_r - CNT_ONE;
               end else begin
                  cnt_nxt_s   = cnt_r;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end
         endcase
      end
      out_valid_nxt_s = (state_nxt_s == SEND);
   end

   // Handshake outputs: a load is possible when idle or when the last word leaves this cycle
   always_comb begin
      load_ready_s  = 1'b0;
      tx_done_nxt_s = 1'b0;
      if (clear) begin
         load_ready_s  = 1'b0;
         tx_done_nxt_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:    load_ready_s = 1'b1;
            SEND:    load_ready_s = (cnt_r == CNT_ONE) && out_ready;
            default: load_ready_s = 1'b0;
         endcase
         tx_done_nxt_s = last_hs_s;
      end
      load_hs_s = load_en && load_ready_s;
   end

   flexbyte_pts_sr #(
      .NUM_BYTES_IN  (NUM_BYTES_IN),
      .NUM_BYTES_OUT (NUM_BYTES_OUT)
   ) u_pts (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .load_enable  (load_hs_s),
      .shift_enable (shift_hs_s),
      .parallel_in  (data_in),
      .serial_out   (data_out)
   );

   assign load_ready = load_ready_s;
   assign out_valid  = out_valid_r;
   assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_tx_sr.sv
// Testbench for tx_sr: directed scenarios followed by random traffic.
// Results are compared against a word-queue reference model.
module tb_tx_sr;
   import tx_sr_pkg::*;

   logic                 clk;
   logic                 n_rst;
   logic [BLOCK_W-1:0]   data_in;
   logic                 load_en;
   logic                 load_ready;
   logic                 clear;
   logic [WORD_W-1:0]    data_out;
   logic                 out_valid;
   logic                 out_ready;
   logic                 tx_done;

   int pass_cnt;
   int total_cnt;

   logic [WORD_W-1:0] q[$];
   logic              exp_done;

   tx_sr dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .data_in    (data_in),
      .load_en    (load_en),
      .load_ready (load_ready),
      .clear      (clear),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .tx_done    (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
      total_cnt = total_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_outputs(input logic clr, input logic ordy);
      logic [WORD_W-1:0] exp_data;
      logic exp_valid;
      logic exp_lr;
      exp_valid = (q.size() != 0);
      exp_data  = exp_valid ? q[0] : 32'h0;
      exp_lr    = !clr && ((q.size() == 0) || ((q.size() == 1) && ordy));
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
      chk("data_out", data_out, exp_data);
      chk("tx_done", {31'h0, tx_done}, {31'h0, exp_done});
      chk("load_ready", {31'h0, load_ready}, {31'h0, exp_lr});
   endtask

   // One clock cycle: drive inputs, check against the model, advance the model, then cross the edge.
   task automatic step(input logic le, input logic [BLOCK_W-1:0] din, input logic ordy, input logic clr);
      logic lr;
      logic popped_last;
      load_en   = le;
      data_in   = din;
      out_ready = ordy;
      clear     = clr;
      #1;
      check_outputs(clr, ordy);
      lr = !clr && ((q.size() == 0) || ((q.size() == 1) && ordy));
      popped_last = 1'b0;
      if (clr) begin
         q.delete();
      end else begin
         if ((q.size() != 0) && ordy) begin
            popped_last = (q.size() == 1);
            void'(q.pop_front());
         end
         if (le && lr) begin
            for (int i = 0; i < NUM_WORDS; i++)
               q.push_back(WORD_W'(din >> (WORD_W * (NUM_WORDS - 1 - i))));
         end
      end
      exp_done = popped_last;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   localparam logic [BLOCK_W-1:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [BLOCK_W-1:0] B2 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDC0DE;

   initial begin
      logic [6:0] pat;
      pass_cnt  = 0;
      total_cnt = 0;
      exp_done  = 1'b0;
      n_rst     = 1'b0;
      load_en   = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      #12;
      check_outputs(1'b0, 1'b0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // Plan 1: a single block with out_ready held high
      step(1'b1, B1, 1'b1, 1'b0);
      idle_steps(6);

      // Plan 2: out_ready toggling
      step(1'b1, B1, 1'b0, 1'b0);
      pat = 7'b1011001;
      for (int i = 6; i >= 0; i--) step(1'b0, '0, pat[i], 1'b0);
      idle_steps(3);

      // Plan 3: back-to-back blocks
      step(1'b1, B1, 1'b1, 1'b0);
      idle_steps(3);
      step(1'b1, B2, 1'b1, 1'b0);
      idle_steps(6);

      // Plan 4: load_en while the block is in flight
      step(1'b1, B1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, B2, 1'b0, 1'b0);
      step(1'b1, B2, 1'b1, 1'b0);
      idle_steps(5);

      // Plan 5: clear after word 2, with a simultaneous load attempt
      step(1'b1, B1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, B2, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, B2, 1'b1, 1'b0);
      idle_steps(6);

      // Plan 6: asynchronous reset mid-block
      step(1'b1, B1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      load_en = 1'b0;
      n_rst   = 1'b0;
      #1;
      q.delete();
      exp_done = 1'b0;
      check_outputs(1'b0, 1'b1);
      #1;
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      idle_steps(2);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 2) != 0),
              {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 40) == 0));
      end
      idle_steps(6);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
